// File: rtl/rng_port_pkg.sv
// Shared register map, bit positions and reset constants for the RNG bus port.
package rng_port_pkg;

  localparam logic RNG_DATA_ADDR = 1'b0;
  localparam logic RNG_CTRL_ADDR = 1'b1;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int ST_FULL_BIT      = 7;
  localparam int ST_EMPTY_BIT     = 6;
  localparam int ST_UNDERFLOW_BIT = 5;
  localparam int ST_IRQ_EN_BIT    = 4;
  localparam int ST_EN_BIT        = 3;

  localparam logic [7:0] RNG_CTRL_RST  = 8'h01;
  localparam logic [7:0] RNG_RDATA_RST = 8'h00;

  function automatic logic [7:0] pack_status(input logic full, input logic empty,
                                             input logic underflow, input logic irq_en,
                                             input logic en, input logic [2:0] count);
    logic [7:0] s;
    s                   = 8'h00;
    s[ST_FULL_BIT]      = full;
    s[ST_EMPTY_BIT]     = empty;
    s[ST_UNDERFLOW_BIT] = underflow;
    s[ST_IRQ_EN_BIT]    = irq_en;
    s[ST_EN_BIT]        = en;
    s[2:0]              = count;
    return s;
  endfunction

endpackage

// File: rtl/rng_fifo.sv
// Small byte FIFO for sampled RNG values; a pop frees the slot for a same-cycle push.
module rng_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 2) ? 2 : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == 3'(DEPTH));
  assign empty   = (count == 3'd0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign dout    = mem[rptr];

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= 3'd0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rng_bus_port.sv
// CPU-facing RNG port: sample divider, DATA/STATUS-CTRL decode and registered rdata.
// Optional interrupt output is built when RNG_PORT_IRQ_EN is defined.
module rng_bus_port
  import rng_port_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int SAMPLE_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rng_in,
  input  logic       cs,
  input  logic       addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
`ifdef RNG_PORT_IRQ_EN
  ,
  output logic       irq
`endif
);

  logic [7:0] div_cnt;
  logic       en;
  logic       underflow;
  logic       irq_en_bit;
  logic       data_rd;
  logic       stat_rd;
  logic       ctrl_wr;
  logic       flush;
  logic       sample;
  logic [7:0] fifo_dout;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] status;

  assign data_rd = cs & rd & (addr == RNG_DATA_ADDR);
  assign stat_rd = cs & rd & (addr == RNG_CTRL_ADDR);
  assign ctrl_wr = cs & wr & (addr == RNG_CTRL_ADDR);
  assign flush   = ctrl_wr & wdata[CTRL_FLUSH_BIT];
  assign sample  = en & (div_cnt == 8'(SAMPLE_DIV - 1));
  assign status  = pack_status(fifo_full, fifo_empty, underflow, irq_en_bit, en, fifo_count);

  rng_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (sample),
    .pop   (data_rd),
    .flush (flush),
    .din   (rng_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= 8'd0;
      en        <= RNG_CTRL_RST[CTRL_EN_BIT];
      underflow <= 1'b0;
      rdata     <= RNG_RDATA_RST;
    end else begin
      if (flush || !en || sample) div_cnt <= 8'd0;
      else                        div_cnt <= div_cnt + 8'd1;

      if (ctrl_wr) en <= wdata[CTRL_EN_BIT];

      // Registers are sampled before any same-cycle write lands.
      if (data_rd)      rdata <= fifo_empty ? 8'h00 : fifo_dout;
      else if (stat_rd) rdata <= status;

      if (data_rd && fifo_empty && !flush) underflow <= 1'b1;
      else if (stat_rd)                    underflow <= 1'b0;
    end
  end

`ifdef RNG_PORT_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= RNG_CTRL_RST[CTRL_IRQ_EN_BIT];
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= wdata[CTRL_IRQ_EN_BIT];
      irq <= irq_en & ~fifo_empty;
    end
  end

  assign irq_en_bit = irq_en;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[7:3]};
`else
  assign irq_en_bit = 1'b0;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[7:2]};
`endif

endmodule
